bmc_soft_pipe: RTL and testbench
================================

BMC_SOFT_PIPE -- requirements
Module: bmc_soft_pipe

Interface
REQ-001 Parameter N, default 2: code outputs per trellis branch (rate 1/N), legal range 1..4.
REQ-002 Parameter SW, default 3: soft-symbol width in bits, offset-binary; SW=1 is hard decision. Legal range 1..6.
REQ-003 Parameter P, default 1: puncture period in input beats, legal range 1..8.
REQ-004 Parameter PUNCT_MASK, default all ones, width N*P: bit p*N+j=1 keeps symbol j at phase p; 0 erases it.
REQ-005 Derived BMW = SW + clog2(N): width of one branch metric.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 in_valid  input  1  rx_sym carries a valid beat.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 rx_sym  input  N*SW  symbol j at bits [j*SW +: SW].
REQ-011 frame_start  input  1  qualified by in_valid; the beat is puncture phase 0.
REQ-012 out_valid  output  1  bm and out_erase are valid.
REQ-013 out_ready  input  1  downstream ACS accepts.
REQ-014 bm  output  (2^N)*BMW  metric for hypothesis h at bits [h*BMW +: BMW]; bit j of h is the expected code bit of symbol j.
REQ-015 out_erase  output  N  bit j=1 means symbol j was punctured for this beat.

Function
REQ-016 Beat accepted iff in_valid && in_ready; in_ready = !out_valid || out_ready (single registered stage, no combinational in_valid->in_ready path).
REQ-017 Per-symbol distance: expected 0 -> r; expected 1 -> (2^SW-1) - r; erased symbol -> 0 for both.
REQ-018 bm[h] = unsigned sum of the N per-symbol distances; no saturation required, since max N*(2^SW-1) fits in BMW.
REQ-019 Latency is one cycle: bm, out_erase, and out_valid register on the accepting edge.
REQ-020 Output register holds bm and out_erase stable while out_valid && !out_ready.
REQ-021 Simultaneous output consumption and new acceptance loads the new beat with no bubble; sustained throughput is 1 beat/clk.
REQ-022 Phase counter 0..P-1 selects the PUNCT_MASK slice and advances only on an accepted beat, wrapping P-1 -> 0.
REQ-023 An accepted beat with frame_start uses phase 0, and the next phase is 1 mod P; frame_start overrides wrap and current count.
REQ-024 frame_start without in_valid, or on a beat not accepted, has no effect.
REQ-025 If P=1, the phase stays 0 and PUNCT_MASK applies on every beat.
REQ-026 SW=1, N=2, P=1 is bit-exact with the existing hard-decision rate-1/2 Hamming BMC (metrics 0..2).

Reset
REQ-027 rst_n low: out_valid=0, bm=0, out_erase=0, phase=0, immediately and independent of clk.
REQ-028 A beat held in the output register when rst_n asserts is discarded.
REQ-029 in_ready=1 from the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package bmc_pkg holds the BMW width function, hypothesis/expected-bit helper, and legal-range constants for N/SW/P.
REQ-031 Sub-module bmc_sym_dist (one SW-bit symbol + erase -> dist0, dist1), instantiated N times.
REQ-032 The top level contains the phase counter, mask slicing, 2^N adders, and the output register/handshake.

Verification
REQ-033 N=2,SW=1: rx_sym=2'b10 accepted -> next cycle out_valid=1; bm[0..3]=1,2,0,1.
REQ-034 N=2,SW=3: sym0=7,sym1=0 -> bm[0..3]=7,0,14,7; out_erase=0.
REQ-035 P=2,PUNCT_MASK=4'b0111: beat with frame_start then beat sym0=7,sym1=5 -> second beat bm=7,0,7,0, out_erase=2'b10; third beat is phase 0 again.
REQ-036 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, bm unchanged; out_ready=1 -> exactly one transfer per clk, no loss or duplication across 100 random beats checked against a model.
REQ-037 frame_start at phase 1 of P=3 -> that beat uses phase 0 mask; the following beat uses phase 1.
REQ-038 rst_n pulled low mid-stall -> out_valid=0 and bm=0 asynchronously; after release, phase=0 on the first beat.

Source files
------------

// File: rtl/bmc_pkg.sv
// Shared definitions for the soft-decision branch-metric pipeline: metric width,
// hypothesis-to-expected-bit mapping and the legal parameter ranges.
package bmc_pkg;

  localparam int N_MIN  = 1;
  localparam int N_MAX  = 4;
  localparam int SW_MIN = 1;
  localparam int SW_MAX = 6;
  localparam int P_MIN  = 1;
  localparam int P_MAX  = 8;

  // Width that holds N summed distances of (2^SW - 1) without overflow.
  function automatic int bm_width(input int n, input int sw);
    return sw + $clog2(n);
  endfunction

  // Expected code bit of symbol j under hypothesis h.
  function automatic logic exp_bit(input int h, input int j);
    return 1'((h >> j) & 1);
  endfunction

endpackage

// File: rtl/bmc_sym_dist.sv
// Distance of one offset-binary soft symbol to an expected 0 and to an expected 1.
// Erased (punctured) symbols contribute nothing to either hypothesis.
module bmc_sym_dist #(
  parameter int SW = 3
) (
  input  logic [SW-1:0] sym,
  input  logic          erase,
  output logic [SW-1:0] dist0,
  output logic [SW-1:0] dist1
);

  // (2^SW - 1) - r is the bitwise complement of r.
  assign dist0 = erase ? '0 : sym;
  assign dist1 = erase ? '0 : ~sym;

endmodule

// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric calculator with puncturing and a single
// registered output stage behind a valid/ready handshake.
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter int                N          = 2,
  parameter int                SW         = 3,
  parameter int                P          = 1,
  parameter logic [N*P-1:0]    PUNCT_MASK = '1,
  localparam int               BMW        = bm_width(N, SW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*SW-1:0]         rx_sym,
  input  logic                    frame_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**N)*BMW-1:0]   bm,
  output logic [N-1:0]            out_erase
);

  localparam int             NH         = 2**N;
  localparam int             PW         = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(P - 1);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("bmc_soft_pipe: N out of range");
  end
  if (SW < SW_MIN || SW > SW_MAX) begin : g_bad_sw
    $error("bmc_soft_pipe: SW out of range");
  end
  if (P < P_MIN || P > P_MAX) begin : g_bad_p
    $error("bmc_soft_pipe: P out of range");
  end

  logic [PW-1:0]     phase_p0;
  logic [PW-1:0]     phase_sel;
  logic [PW-1:0]     phase_nxt;
  logic              accept;
  logic [N-1:0]      erase_p0;
  logic [SW-1:0]     dist0_p0 [N];
  logic [SW-1:0]     dist1_p0 [N];
  logic [NH*BMW-1:0] bm_p0;

  logic              vld_p1;
  logic [NH*BMW-1:0] bm_p1;
  logic [N-1:0]      erase_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // frame_start forces phase 0 for the current beat; only accepted beats advance.
  assign phase_sel = frame_start ? '0 : phase_p0;
  assign phase_nxt = (phase_sel == PHASE_LAST) ? '0 : phase_sel + PW'(1);
  assign erase_p0  = ~PUNCT_MASK[phase_sel*N +: N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_p0 <= '0;
    end else if (accept) begin
      phase_p0 <= phase_nxt;
    end
  end

  // ---- stage p0: per-symbol distances and hypothesis sums ----
  for (genvar j = 0; j < N; j++) begin : g_dist
    bmc_sym_dist #(.SW(SW)) u_dist (
      .sym   (rx_sym[j*SW +: SW]),
      .erase (erase_p0[j]),
      .dist0 (dist0_p0[j]),
      .dist1 (dist1_p0[j])
    );
  end

  always_comb begin : sum_p0
    logic [BMW-1:0] acc;
    bm_p0 = '0;
    acc   = '0;
    for (int h = 0; h < NH; h++) begin
      acc = '0;
      for (int j = 0; j < N; j++) begin
        acc = acc + BMW'(exp_bit(h, j) ? dist1_p0[j] : dist0_p0[j]);
      end
      bm_p0[h*BMW +: BMW] = acc;
    end
  end

  // ---- stage p1: output register, held while downstream stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      bm_p1    <= '0;
      erase_p1 <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      bm_p1    <= bm_p0;
      erase_p1 <= erase_p0;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign bm        = bm_p1;
  assign out_erase = erase_p1;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Randomized and directed check of bmc_soft_pipe in two configurations
// (N=2/SW=3/P=3 punctured, and N=2/SW=1/P=1 hard decision) against a metric model.
module tb_bmc_soft_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_frame_start, a_out_valid, a_out_ready;
  logic [5:0]  a_rx_sym;
  logic [15:0] a_bm;
  logic [1:0]  a_out_erase;

  logic        b_in_valid, b_in_ready, b_frame_start, b_out_valid, b_out_ready;
  logic [1:0]  b_rx_sym;
  logic [7:0]  b_bm;
  logic [1:0]  b_out_erase;

  int nvec = 0;
  int nmis = 0;

  logic [15:0] q_bm [$];
  logic [1:0]  q_er [$];
  int          ph_m = 0;
  logic        b_vld_m = 1'b0;
  logic [15:0] b_exp = '0;

  always #5 clk = ~clk;

  // Phase 0 keeps both symbols, phase 1 keeps sym0 only, phase 2 keeps sym1 only.
  bmc_soft_pipe #(.N(2), .SW(3), .P(3), .PUNCT_MASK(6'b10_01_11)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rx_sym(a_rx_sym), .frame_start(a_frame_start), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .bm(a_bm), .out_erase(a_out_erase)
  );

  bmc_soft_pipe #(.N(2), .SW(1), .P(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rx_sym(b_rx_sym), .frame_start(b_frame_start), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .bm(b_bm), .out_erase(b_out_erase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] erase_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // Metric for each of 4 hypotheses, fields of (sw+1) bits packed low to high.
  function automatic logic [15:0] ref_bm(input int sw, input int s0, input int s1,
                                         input logic [1:0] er);
    logic [15:0] r;
    int d, s;
    r = '0;
    for (int h = 0; h < 4; h++) begin
      d = 0;
      for (int j = 0; j < 2; j++) begin
        s = (j == 0) ? s0 : s1;
        if (!er[j]) d += (((h >> j) & 1) != 0) ? ((1 << sw) - 1 - s) : s;
      end
      r = r | (16'(d) << (h * (sw + 1)));
    end
    return r;
  endfunction

  task automatic cyc(input logic iv, input logic fs, input logic [5:0] sym, input logic ordy,
                     input logic biv, input logic [1:0] bsym);
    logic vld_m, take, acc;
    int   ph;
    @(negedge clk);
    a_in_valid = iv; a_frame_start = fs; a_rx_sym = sym; a_out_ready = ordy;
    b_in_valid = biv; b_rx_sym = bsym; b_frame_start = fs; b_out_ready = 1'b1;
    #1;
    vld_m = (q_bm.size() != 0);
    chk("a_out_valid", 32'(a_out_valid), 32'(vld_m));
    chk("a_in_ready", 32'(a_in_ready), 32'(!vld_m || ordy));
    if (vld_m) begin
      chk("a_bm", 32'(a_bm), 32'(q_bm[0]));
      chk("a_out_erase", 32'(a_out_erase), 32'(q_er[0]));
    end
    take = vld_m && ordy;
    acc  = iv && (!vld_m || ordy);
    if (take) begin
      void'(q_bm.pop_front());
      void'(q_er.pop_front());
    end
    if (acc) begin
      ph = fs ? 0 : ph_m;
      q_bm.push_back(ref_bm(3, int'(sym[2:0]), int'(sym[5:3]), erase_of(ph)));
      q_er.push_back(erase_of(ph));
      ph_m = (ph + 1) % 3;
    end
    chk("b_out_valid", 32'(b_out_valid), 32'(b_vld_m));
    chk("b_in_ready", 32'(b_in_ready), 32'd1);
    if (b_vld_m) begin
      chk("b_bm", 32'(b_bm), 32'(b_exp[7:0]));
      chk("b_out_erase", 32'(b_out_erase), 32'd0);
    end
    b_vld_m = biv;
    if (biv) b_exp = ref_bm(1, int'(bsym[0]), int'(bsym[1]), 2'b00);
  endtask

  initial begin
    rst_n = 1'b1;
    a_in_valid = 0; a_frame_start = 0; a_rx_sym = '0; a_out_ready = 1;
    b_in_valid = 0; b_frame_start = 0; b_rx_sym = '0; b_out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_bm", 32'(a_bm), 32'd0);
    chk("rst_a_out_erase", 32'(a_out_erase), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: known metrics and puncture phase sequence with frame_start override.
    cyc(1, 1, {3'd0, 3'd7}, 1, 1, 2'b10);
    cyc(1, 0, {3'd5, 3'd7}, 1, 0, 2'b00);
    chk("dir_bm_7_0_14_7", 32'(a_bm), 32'({4'd7, 4'd14, 4'd0, 4'd7}));
    chk("dir_erase_ph0", 32'(a_out_erase), 32'd0);
    chk("dir_hard_1_2_0_1", 32'(b_bm), 32'({2'd1, 2'd0, 2'd2, 2'd1}));
    cyc(1, 0, {3'd1, 3'd2}, 1, 0, 2'b00);
    chk("dir_bm_7_0_7_0", 32'(a_bm), 32'({4'd0, 4'd7, 4'd0, 4'd7}));
    chk("dir_erase_ph1", 32'(a_out_erase), 32'b10);
    cyc(1, 0, {3'd3, 3'd4}, 1, 0, 2'b00);
    chk("dir_erase_ph2", 32'(a_out_erase), 32'b01);
    cyc(1, 1, {3'd6, 3'd1}, 1, 0, 2'b00);
    chk("dir_erase_wrap_ph0", 32'(a_out_erase), 32'b00);
    cyc(1, 0, {3'd2, 3'd5}, 1, 0, 2'b00);
    chk("dir_erase_fs_ph0", 32'(a_out_erase), 32'b00);
    cyc(0, 0, 6'd0, 1, 0, 2'b00);
    chk("dir_erase_after_fs", 32'(a_out_erase), 32'b10);

    // Backpressure: output held for five stalled cycles, then released.
    cyc(1, 0, 6'(($urandom)), 1, 1, 2'($urandom));
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 6'($urandom), 0, 1, 2'($urandom));
      chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    end

    // Random traffic with random stalls and occasional frame_start.
    for (int i = 0; i < 150; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 8) == 0, 6'($urandom), ($urandom % 4) != 0,
          ($urandom % 3) != 0, 2'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1, ($urandom % 8) == 0, 6'($urandom), 1, 1, 2'($urandom));
    end

    // Reset asserted while a beat is stalled in the output register.
    cyc(1, 0, 6'($urandom), 1, 1, 2'($urandom));
    cyc(1, 0, 6'($urandom), 0, 1, 2'($urandom));
    cyc(1, 0, 6'($urandom), 0, 1, 2'($urandom));
    #1;
    a_in_valid = 0; b_in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("async_rst_bm", 32'(a_bm), 32'd0);
    chk("async_rst_erase", 32'(a_out_erase), 32'd0);
    chk("async_rst_b_out_valid", 32'(b_out_valid), 32'd0);
    q_bm.delete();
    q_er.delete();
    ph_m = 0;
    b_vld_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, {3'd0, 3'd7}, 1, 0, 2'b00);
    cyc(1, 0, 6'($urandom), 1, 0, 2'b00);
    chk("post_rst_phase0_erase", 32'(a_out_erase), 32'd0);
    chk("post_rst_bm", 32'(a_bm), 32'({4'd7, 4'd14, 4'd0, 4'd7}));
    for (int i = 0; i < 4; i++) cyc(0, 0, 6'd0, 1, 0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
